data_upload: RTL

//  Uploads a RAM region (e.g. recorded tape/snapshot) to the io controller: the read-side twin of the
//  SPI file-download path. The SPI slave is oversampled in the system clock, bytes are prefetched from
//  the external RAM and shifted out on sdo MSB-first. Sits between the io controller SPI bus and the RAM arbiter.

---
 rtl/data_io_pkg.sv | 17 +
 rtl/spi_sync_edge.sv | 41 ++++
 rtl/data_upload.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/data_io_pkg.sv
// Shared io-controller command codes and the prefetch state type for the SPI upload path.
package data_io_pkg;

  localparam logic [7:0] UIO_FILE_TX     = 8'h53;
  localparam logic [7:0] UIO_FILE_TX_DAT = 8'h54;
  localparam logic [7:0] UIO_FILE_INDEX  = 8'h55;
  localparam logic [7:0] UIO_FILE_RX     = 8'h56;
  localparam logic [7:0] UIO_FILE_RX_DAT = 8'h57;
  localparam logic [7:0] UIO_FILE_RX_SUM = 8'h58;

  typedef enum logic [1:0] {
    PF_IDLE,
    PF_REQ,
    PF_FULL
  } pf_state_t;

endpackage

// File: rtl/spi_sync_edge.sv
// Brings the asynchronous SPI pins into the clk domain and turns sck into one-cycle rise/fall pulses.
module spi_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset_n,
  input  logic sck,
  input  logic ss,
  input  logic sdi,
  output logic sck_rise,
  output logic sck_fall,
  output logic ss_s,
  output logic sdi_s
);

  logic [SYNC_STAGES-1:0] sck_q;
  logic [SYNC_STAGES-1:0] ss_q;
  logic [SYNC_STAGES-1:0] sdi_q;
  logic                   sck_d;

  // ss resets to its idle (high) level so the bit counter stays cleared coming out of reset
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sck_q <= '0;
      ss_q  <= '1;
      sdi_q <= '0;
      sck_d <= 1'b0;
    end else begin
      sck_q <= {sck_q[SYNC_STAGES-2:0], sck};
      ss_q  <= {ss_q[SYNC_STAGES-2:0], ss};
      sdi_q <= {sdi_q[SYNC_STAGES-2:0], sdi};
      sck_d <= sck_q[SYNC_STAGES-1];
    end
  end

  assign sck_rise = sck_q[SYNC_STAGES-1] & ~sck_d;
  assign sck_fall = ~sck_q[SYNC_STAGES-1] & sck_d;
  assign ss_s     = ss_q[SYNC_STAGES-1];
  assign sdi_s    = sdi_q[SYNC_STAGES-1];

endmodule

// File: rtl/data_upload.sv
// Streams a RAM region to the io controller over oversampled SPI with a one-byte prefetch buffer.
// Optional DATA_UPLOAD_CHECKSUM_EN adds a byte checksum readable with command 8'h58.
module data_upload
  import data_io_pkg::*;
#(
  parameter int                ADDR_W      = 25,
  parameter logic [ADDR_W-1:0] BASE_ADDR   = 25'h200000,
  parameter int                SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              sck,
  input  logic              ss,
  input  logic              sdi,
  output logic              sdo,
  input  logic [ADDR_W-1:0] upload_size,
  output logic              uploading,
  output logic              underrun,
  output logic              rd,
  output logic [ADDR_W-1:0] a,
  input  logic [7:0]        din,
  input  logic              rd_ack
`ifdef DATA_UPLOAD_CHECKSUM_EN
  ,
  output logic [7:0]        checksum
`endif
);

  localparam logic [ADDR_W-1:0] ONE = 1;

  logic              sck_rise, sck_fall, ss_s, sdi_s;
  logic [3:0]        bit_cnt;
  logic [6:0]        sbuf;
  logic [7:0]        cmd, eff_cmd;
  logic [7:0]        buffer, shift, held, avail;
  logic              inflight, replay, dat_slot, skip_fall, discard;
  logic [ADDR_W-1:0] addr, remaining;
  logic              slot_end, rx_end, have_data;
  pf_state_t         pf;
`ifdef DATA_UPLOAD_CHECKSUM_EN
  logic [7:0]        sum;
  assign checksum = sum;
`endif

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk      (clk),
    .reset_n  (reset_n),
    .sck      (sck),
    .ss       (ss),
    .sdi      (sdi),
    .sck_rise (sck_rise),
    .sck_fall (sck_fall),
    .ss_s     (ss_s),
    .sdi_s    (sdi_s)
  );

  assign eff_cmd   = (bit_cnt == 4'd7) ? {sbuf, sdi_s} : cmd;
  assign slot_end  = sck_rise && !ss_s && (bit_cnt == 4'd7 || bit_cnt == 4'd15);
  assign rx_end    = sck_rise && !ss_s && bit_cnt == 4'd15 && cmd == UIO_FILE_RX;
  assign have_data = (pf == PF_FULL) || (pf == PF_REQ && rd_ack && !discard);
  assign avail     = (pf == PF_FULL) ? buffer : din;
  assign sdo       = dat_slot & shift[7];

  // A RAM byte sitting in the shift register stays in 'held' until its slot completes,
  // so an ss abort can replay it without touching the already-advanced fetch address.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pf        <= PF_IDLE;
      rd        <= 1'b0;
      a         <= BASE_ADDR;
      addr      <= BASE_ADDR;
      remaining <= '0;
      buffer    <= 8'h00;
      shift     <= 8'h00;
      held      <= 8'h00;
      bit_cnt   <= 4'd0;
      sbuf      <= 7'd0;
      cmd       <= 8'h00;
      uploading <= 1'b0;
      underrun  <= 1'b0;
      inflight  <= 1'b0;
      replay    <= 1'b0;
      dat_slot  <= 1'b0;
      skip_fall <= 1'b0;
      discard   <= 1'b0;
`ifdef DATA_UPLOAD_CHECKSUM_EN
      sum       <= 8'h00;
`endif
    end else begin
      case (pf)
        PF_IDLE: if (uploading && remaining != '0 && !rx_end) begin
          pf <= PF_REQ;
          rd <= 1'b1;
          a  <= addr;
        end
        PF_REQ: if (rd_ack) begin
          rd <= 1'b0;
          if (discard) begin
            pf      <= PF_IDLE;
            discard <= 1'b0;
          end else begin
            pf     <= PF_FULL;
            buffer <= din;
          end
        end
        PF_FULL: ;
        default: pf <= PF_IDLE;
      endcase

      if (ss_s) begin
        bit_cnt  <= 4'd0;
        dat_slot <= 1'b0;
        if (inflight) begin
          replay   <= 1'b1;
          inflight <= 1'b0;
        end
      end else if (sck_fall) begin
        if (skip_fall) skip_fall <= 1'b0;
        else           shift     <= {shift[6:0], 1'b0};
      end else if (sck_rise) begin
        sbuf    <= {sbuf[5:0], sdi_s};
        bit_cnt <= (bit_cnt == 4'd15) ? 4'd8 : bit_cnt + 4'd1;
        if (bit_cnt == 4'd7) cmd <= {sbuf, sdi_s};

        if (slot_end) begin
          skip_fall <= 1'b1;
          dat_slot  <= 1'b0;
          inflight  <= 1'b0;
          if (eff_cmd == UIO_FILE_RX_DAT) begin
            dat_slot <= 1'b1;
            if (replay) begin
              shift    <= held;
              inflight <= 1'b1;
              replay   <= 1'b0;
            end else if (uploading && remaining != '0) begin
              if (have_data) begin
                shift     <= avail;
                held      <= avail;
                inflight  <= 1'b1;
                pf        <= PF_IDLE;
                addr      <= addr + ONE;
                remaining <= remaining - ONE;
`ifdef DATA_UPLOAD_CHECKSUM_EN
                sum       <= sum + avail;
`endif
              end else begin
                shift    <= 8'hFF;
                underrun <= 1'b1;
              end
            end else begin
              shift     <= 8'h00;
              uploading <= 1'b0;
            end
          end
`ifdef DATA_UPLOAD_CHECKSUM_EN
          else if (eff_cmd == UIO_FILE_RX_SUM) begin
            dat_slot <= 1'b1;
            shift    <= sum;
          end
`endif
        end

        // A read still outstanding at start/stop must finish on the bus; its data is dropped
        if (rx_end) begin
          uploading <= sdi_s;
          replay    <= 1'b0;
          if (pf == PF_REQ && !rd_ack) begin
            discard <= 1'b1;
          end else begin
            pf      <= PF_IDLE;
            discard <= 1'b0;
          end
          if (sdi_s) begin
            addr      <= BASE_ADDR;
            remaining <= upload_size;
            underrun  <= 1'b0;
`ifdef DATA_UPLOAD_CHECKSUM_EN
            sum       <= 8'h00;
`endif
          end
        end
      end
    end
  end

endmodule
